master_out_stage: RTL and testbench

//  Final output stage between the last effect in the chain (loop1 output) and AudPlayer.

---
 rtl/master_out_stage.sv | 161 ++++++++++++++++
 tb/tb_master_out_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/master_out_stage.sv
// Master output stage: click-free volume ramp, mute, soft-knee limiter and peak/clip meter.
// Optional one-pole DC blocker ahead of the multiplier when MASTER_OUT_DC_BLOCK_EN is defined.
module master_out_stage #(
  parameter int LIMIT_THRESH = 28000,
  parameter int PEAK_HOLD    = 4800,
  parameter int RAMP_STEP    = 1
) (
  input  logic        i_AUD_BCLK,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  input  logic [2:0]  i_level,
  input  logic        i_mute,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic [3:0]  o_peak,
  output logic        o_clip
);

  localparam int CW = $clog2(PEAK_HOLD + 1);

  typedef enum logic [2:0] {S_IDLE, S_DCB, S_MUL, S_LIM, S_OUT} state_t;

  state_t               state_reg, state_next;
  logic signed [15:0]   sample_reg;
  logic [2:0]           level_reg;
  logic                 mute_reg;
  logic [7:0]           gain_reg, gain_next, gain_target;
  logic signed [24:0]   prod;
  logic signed [17:0]   x_reg, x_next;
  logic [17:0]          abs_x, lim_mag;
  logic                 over;
  logic [14:0]          sat_mag;
  logic [15:0]          result, abs_res;
  logic [15:0]          peak_reg, peak_next;
  logic [CW-1:0]        hold_reg, hold_next, clip_reg, clip_next;

`ifdef MASTER_OUT_DC_BLOCK_EN
  logic signed [15:0] x_prev_reg, y_prev_reg, dcb_sat;
  logic signed [17:0] dcb_y;

  always_comb begin
    dcb_y = 18'(sample_reg) - 18'(x_prev_reg) + 18'(y_prev_reg) - 18'(y_prev_reg >>> 8);
    if (dcb_y > 18'sd32767)
      dcb_sat = 16'sh7fff;
    else if (dcb_y < -18'sd32768)
      dcb_sat = 16'sh8000;
    else
      dcb_sat = dcb_y[15:0];
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (i_valid) begin
`ifdef MASTER_OUT_DC_BLOCK_EN
        state_next = S_DCB;
`else
        state_next = S_MUL;
`endif
      end
      S_DCB:   state_next = S_MUL;
      S_MUL:   state_next = S_LIM;
      S_LIM:   state_next = S_OUT;
      S_OUT:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Gain ramp: one step toward the target per accepted sample, clamped at the target.
  always_comb begin
    gain_target = (mute_reg || level_reg == 3'd0) ? 8'd0 : {4'(level_reg) + 4'd1, 4'b0000};
    if (gain_reg < gain_target)
      gain_next = (gain_target - gain_reg > 8'(RAMP_STEP)) ? gain_reg + 8'(RAMP_STEP) : gain_target;
    else if (gain_reg > gain_target)
      gain_next = (gain_reg - gain_target > 8'(RAMP_STEP)) ? gain_reg - 8'(RAMP_STEP) : gain_target;
    else
      gain_next = gain_reg;
  end

  assign prod   = sample_reg * $signed({1'b0, gain_reg});
  assign x_next = 18'(prod >>> 7);

  always_comb begin
    abs_x   = x_reg[17] ? 18'(-x_reg) : 18'(x_reg);
    over    = abs_x > 18'(LIMIT_THRESH);
    lim_mag = over ? 18'(LIMIT_THRESH) + ((abs_x - 18'(LIMIT_THRESH)) >> 2) : abs_x;
    sat_mag = (lim_mag > 18'd32767) ? 15'h7fff : lim_mag[14:0];
    abs_res = {1'b0, sat_mag};
    result  = x_reg[17] ? 16'(-abs_res) : abs_res;
  end

  always_comb begin
    peak_next = peak_reg;
    hold_next = hold_reg;
    if (abs_res > peak_reg) begin
      peak_next = abs_res;
      hold_next = CW'(PEAK_HOLD);
    end else if (hold_reg != '0) begin
      hold_next = hold_reg - 1'b1;
    end else begin
      peak_next = peak_reg - (peak_reg >> 4);
    end
    clip_next = over ? CW'(PEAK_HOLD) : ((clip_reg != '0) ? clip_reg - 1'b1 : clip_reg);
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= S_IDLE;
      sample_reg <= '0;
      level_reg  <= '0;
      mute_reg   <= 1'b0;
      gain_reg   <= '0;
      x_reg      <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      peak_reg   <= '0;
      hold_reg   <= '0;
      clip_reg   <= '0;
`ifdef MASTER_OUT_DC_BLOCK_EN
      x_prev_reg <= '0;
      y_prev_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      o_valid   <= 1'b0;
      case (state_reg)
        S_IDLE: if (i_valid) begin
          sample_reg <= i_data;
          level_reg  <= i_level;
          mute_reg   <= i_mute;
        end
`ifdef MASTER_OUT_DC_BLOCK_EN
        S_DCB: begin
          sample_reg <= dcb_sat;
          x_prev_reg <= sample_reg;
          y_prev_reg <= dcb_sat;
        end
`endif
        S_MUL: begin
          x_reg    <= x_next;
          gain_reg <= gain_next;
        end
        // Output and meter are registered together so o_valid is high while in S_OUT.
        S_LIM: begin
          o_data   <= result;
          o_valid  <= 1'b1;
          peak_reg <= peak_next;
          hold_reg <= hold_next;
          clip_reg <= clip_next;
        end
        default: ;
      endcase
    end
  end

  assign o_peak = peak_reg[15:12];
  assign o_clip = (clip_reg != '0);

endmodule

// File: tb/tb_master_out_stage.sv
// Randomised and directed bench for master_out_stage against an arithmetic reference model.
module tb_master_out_stage;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic [15:0] i_data;
  logic [2:0]  i_level;
  logic        i_mute;
  logic [15:0] o_data;
  logic        o_valid;
  logic [3:0]  o_peak;
  logic        o_clip;

  master_out_stage dut (
    .i_AUD_BCLK(clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_level   (i_level),
    .i_mute    (i_mute),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_peak    (o_peak),
    .o_clip    (o_clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int data;
    int peak;
    int clip;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   checking = 0;

  // Model state
  int m_gain = 0, m_peak = 0, m_hold = 0, m_clipc = 0;
  int held_data = 0, held_peak = 0, held_clip = 0;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_gain = 0; m_peak = 0; m_hold = 0; m_clipc = 0;
    held_data = 0; held_peak = 0; held_clip = 0;
  endtask

  task automatic model_push(int d, int lvl, int m);
    int tgt, x, a, res;
    bit clip;
    exp_t e;
    tgt = m ? 0 : ((lvl == 0) ? 0 : 16 * (lvl + 1));
    x = (d * m_gain) >>> 7;
    if (m_gain < tgt) m_gain = (m_gain + 1 > tgt) ? tgt : m_gain + 1;
    else if (m_gain > tgt) m_gain = (m_gain - 1 < tgt) ? tgt : m_gain - 1;
    a = (x < 0) ? -x : x;
    clip = (a > 28000);
    if (clip) a = 28000 + (a - 28000) / 4;
    if (a > 32767) a = 32767;
    res = (x < 0) ? -a : a;
    if (a > m_peak) begin
      m_peak = a; m_hold = 4800;
    end else if (m_hold > 0) m_hold--;
    else m_peak = m_peak - m_peak / 16;
    if (clip) m_clipc = 4800;
    else if (m_clipc > 0) m_clipc--;
    e.due = cyc + LAT; e.data = res; e.peak = m_peak / 4096; e.clip = (m_clipc != 0);
    q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle compare against the model's expected output stream.
  always @(negedge clk) begin
    if (checking) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("o_valid_pulse", int'(o_valid), 1);
        chk("o_data", int'($signed(o_data)), q[0].data);
        chk("o_peak", int'(o_peak), q[0].peak);
        chk("o_clip", int'(o_clip), q[0].clip);
        held_data = q[0].data; held_peak = q[0].peak; held_clip = q[0].clip;
        void'(q.pop_front());
      end else begin
        chk("o_valid_idle", int'(o_valid), 0);
        chk("o_data_hold", int'($signed(o_data)), held_data);
        chk("o_peak_hold", int'(o_peak), held_peak);
        chk("o_clip_hold", int'(o_clip), held_clip);
        if (q.size() > 0 && q[0].due < cyc) begin
          chk("o_valid_missing", 0, 1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(int d, int lvl, int m, int gap);
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'(d); i_level = 3'(lvl); i_mute = m[0];
    model_push(d, lvl, m);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_o_data", int'(o_data), 0);
    chk("rst_o_valid", int'(o_valid), 0);
    chk("rst_o_peak", int'(o_peak), 0);
    chk("rst_o_clip", int'(o_clip), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_level = 3'd7; i_mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_o_data", int'(o_data), 0);
    chk("reset_o_valid", int'(o_valid), 0);
    chk("reset_o_peak", int'(o_peak), 0);
    chk("reset_o_clip", int'(o_clip), 0);
    rst_n = 1'b1;
    checking = 1;

    // Fade-in from reset at full volume
    for (int n = 0; n < 200; n++) begin
      send(1000, 7, 0, 5 + int'($urandom_range(0, 3)));
      if (n == 1)   chk("fade_n1", int'($signed(o_data)), 7);
      if (n == 64)  chk("fade_n64", int'($signed(o_data)), 500);
      if (n == 199) chk("fade_steady", int'($signed(o_data)), 1000);
    end

    // Limiter at unity
    send(30000, 7, 0, 6);
    chk("lim_pos", int'($signed(o_data)), 28500);
    chk("lim_clip", int'(o_clip), 1);
    send(-32768, 7, 0, 6);
    chk("lim_neg_min", int'($signed(o_data)), -29192);
    send(27000, 7, 0, 6);
    chk("lim_below_knee", int'($signed(o_data)), 27000);

    // Mute fades out 100 per sample, unmute ramps back
    for (int n = 0; n < 130; n++) begin
      send(12800, 7, 1, 5);
      if (n == 0)   chk("mute_first", int'($signed(o_data)), 12800);
      if (n == 1)   chk("mute_second", int'($signed(o_data)), 12700);
      if (n == 128) chk("mute_zero", int'($signed(o_data)), 0);
    end
    for (int n = 0; n < 20; n++) begin
      send(12800, 7, 0, 5);
      if (n == 3) chk("unmute_ramp", int'($signed(o_data)), 300);
    end

    // Back-to-back i_valid: second pulse must be dropped
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'(5000); i_level = 3'd7; i_mute = 1'b0;
    model_push(5000, 7, 0);
    @(negedge clk);
    i_data = 16'(-7000);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (8) @(negedge clk);

    // Peak hold and decay
    do_reset();
    for (int n = 0; n < 130; n++) send(0, 7, 0, 5);
    send(20000, 7, 0, 5);
    chk("peak_load", int'(o_peak), 4);
    chk("peak_noclip", int'(o_clip), 0);
    for (int n = 0; n < 4800; n++) send(0, 7, 0, 5);
    chk("peak_held", int'(o_peak), 4);
    for (int n = 0; n < 40; n++) send(0, 7, 0, 5);
    chk("peak_decayed", int'(o_peak), 0);
    chk("peak_decay_noclip", int'(o_clip), 0);

    // Reset between i_valid and o_valid, mid-ramp
    do_reset();
    for (int n = 0; n < 3; n++) send(1000, 7, 0, 5);
    @(negedge clk);
    i_valid = 1'b1; i_data = 16'(20000);
    @(negedge clk);
    i_valid = 1'b0;
    do_reset();
    repeat (6) @(negedge clk);
    send(1000, 7, 0, 6);
    chk("post_rst_gain0", int'($signed(o_data)), 0);
    send(1000, 7, 0, 6);
    chk("post_rst_gain1", int'($signed(o_data)), 7);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      int d, lvl, m;
      d   = int'($urandom_range(0, 65535)) - 32768;
      lvl = int'($urandom_range(0, 7));
      m   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      send(d, lvl, m, 5 + int'($urandom_range(0, 5)));
    end

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
